d_e_reg: RTL
============

# d_e_reg

Pipeline register between the D stage and the E stage of the five-stage MIPS core. It latches the forwarded operands produced in D along with instruction, PC, extended immediate, destination register and Tnew. It inserts a bubble whenever the hazard unit stalls D. Its E-side outputs feed the E-stage forwarding muxes, the ALU, and the hazard unit's Tnew/A3 comparison.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- stall  input  1  from the hazard unit; 1 = D is frozen this cycle and E must receive a bubble.
- instr_D  input  32  instruction word in D.
- pc_D  input  32  PC of the instruction in D.
- rs_D  input  32  forwarded rs value.
- rt_D  input  32  forwarded rt value.
- ext_D  input  32  sign- or zero-extended immediate from D.
- a3_D  input  5  destination register of the instruction in D; 0 = no write.
- tnew_D  input  2  Tnew of the instruction measured at D (0..3).
- instr_E, pc_E, rs_E, rt_E, ext_E  output  32 each  latched copies for E.
- pc8_E  output  32  pc_E + 8, the link value for jal/jalr.
- a3_E  output  5  destination register in E.
- tnew_E  output  2  Tnew of the instruction now in E.
- valid_E  output  1  1 = E holds a real instruction; 0 = bubble or post-reset.
- bubble_cnt  output  32  number of bubbles inserted since reset.

## Operation
- Priority, highest first: reset > stall > normal load.
- Reset, asynchronous, at any time including mid-stall:
  - All 32-bit data outputs go to 0.
  - pc_E = 0x0000_3000, the core's reset PC, so pc8_E = 0x0000_3008.
  - a3_E = 0, tnew_E = 0, valid_E = 0, bubble_cnt = 0.
- Stall at a clock edge (bubble):
  - instr_E = 0 (sll $0,$0,0, i.e. nop).
  - rs_E, rt_E, ext_E = 0.
  - a3_E = 0, tnew_E = 0, valid_E = 0.
  - pc_E holds its previous value, so debug traces keep the last PC.
  - bubble_cnt increments by 1 and wraps 0xFFFF_FFFF -> 0.
- Normal load at a clock edge:
  - All D inputs are copied to their E outputs.
  - valid_E = 1.
  - tnew_E = tnew_D - 1, saturating at 0 (0 -> 0, 1 -> 0, 2 -> 1, 3 -> 2).
  - a3_D = 0 is stored as 0. When a3_D = 0, tnew_E is forced to 0 so $0 never creates a hazard.
- pc8_E is combinational: pc_E + 8, modulo 2^32, with no overflow flag. 0xFFFF_FFFC + 8 = 0x0000_0004.
- No other internal state; no handshake beyond stall.

## Timing
- Latency is 1 cycle: D values present before edge N appear on E outputs just after edge N.
- All outputs are registered except pc8_E, which is one adder delay after pc_E.
- Consecutive stalls: each stalled edge inserts one more bubble and increments bubble_cnt once per edge.
- Stall deasserted: the held D instruction loads on the first non-stalled edge.
- Reset deassertion takes effect asynchronously; the first load occurs on the first rising edge with reset low.
- Reset asserted in the same cycle as stall: reset wins and bubble_cnt stays 0.

## Test plan
- Reset: assert reset between edges -> immediately instr_E=0, pc_E=0x3000, pc8_E=0x3008, valid_E=0, bubble_cnt=0.
- Normal load: instr_D=0x8C22_0004, pc_D=0x3010, rs_D=0x11, rt_D=0x22, ext_D=4, a3_D=2, tnew_D=2, stall=0, one edge -> E outputs match inputs, pc8_E=0x3018, tnew_E=1, valid_E=1.
- Stall: same D inputs with stall=1 for 3 edges -> instr_E=0, a3_E=0, tnew_E=0, valid_E=0, pc_E unchanged, bubble_cnt=3. Then stall=0 for one edge -> the D instruction appears with valid_E=1.
- Tnew/A3 rules:
  - tnew_D=0, a3_D=5 -> tnew_E=0.
  - tnew_D=3, a3_D=5 -> tnew_E=2.
  - tnew_D=3, a3_D=0 -> tnew_E=0, a3_E=0.
- Wrap and overflow:
  - Preload bubble_cnt to 0xFFFF_FFFF (force), one stalled edge -> bubble_cnt=0.
  - pc_D=0xFFFF_FFFC loaded -> pc8_E=0x0000_0004.
- Reset mid-stall: stall=1, bubble_cnt=7, assert reset asynchronously -> all outputs immediately at reset values. After release with stall=0, the next edge loads D normally.

Source files
------------

// File: rtl/d_e_reg.sv
`default_nettype none
// ============================================================================
// Module   : d_e_reg
// Purpose  : D->E pipeline register of the five-stage MIPS core. Inserts a
//            bubble on stall, decrements Tnew and counts inserted bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module d_e_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_D,
    input  logic [31:0] pc_D,
    input  logic [31:0] rs_D,
    input  logic [31:0] rt_D,
    input  logic [31:0] ext_D,
    input  logic [4:0]  a3_D,
    input  logic [1:0]  tnew_D,
    output logic [31:0] instr_E,
    output logic [31:0] pc_E,
    output logic [31:0] rs_E,
    output logic [31:0] rt_E,
    output logic [31:0] ext_E,
    output logic [31:0] pc8_E,
    output logic [4:0]  a3_E,
    output logic [1:0]  tnew_E,
    output logic        valid_E,
    output logic [31:0] bubble_cnt
);

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_LINK_OFS = 32'd8;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] r_ext;
    logic [4:0]  r_a3;
    logic [1:0]  r_tnew;
    logic        r_valid;
    logic [31:0] r_bubble_cnt;

    logic [1:0]  w_tnew_next;

    // Tnew is one stage older in E; writes to $0 must never look like a hazard.
    always_comb begin
        w_tnew_next = 2'd0;
        if ((a3_D != 5'd0) && (tnew_D != 2'd0)) begin
            w_tnew_next = tnew_D - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr      <= 32'd0;
            r_pc         <= C_RESET_PC;
            r_rs         <= 32'd0;
            r_rt         <= 32'd0;
            r_ext        <= 32'd0;
            r_a3         <= 5'd0;
            r_tnew       <= 2'd0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= 32'd0;
        end else if (stall) begin
            // Bubble: nop with no destination; pc is kept for debug traces.
            r_instr      <= 32'd0;
            r_rs         <= 32'd0;
            r_rt         <= 32'd0;
            r_ext        <= 32'd0;
            r_a3         <= 5'd0;
            r_tnew       <= 2'd0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_instr      <= instr_D;
            r_pc         <= pc_D;
            r_rs         <= rs_D;
            r_rt         <= rt_D;
            r_ext        <= ext_D;
            r_a3         <= a3_D;
            r_tnew       <= w_tnew_next;
            r_valid      <= 1'b1;
        end
    end

    assign instr_E    = r_instr;
    assign pc_E       = r_pc;
    assign rs_E       = r_rs;
    assign rt_E       = r_rt;
    assign ext_E      = r_ext;
    assign a3_E       = r_a3;
    assign tnew_E     = r_tnew;
    assign valid_E    = r_valid;
    assign bubble_cnt = r_bubble_cnt;
    assign pc8_E      = r_pc + C_LINK_OFS;

endmodule
`default_nettype wire
